lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
- Load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address and rs2 as store data, and runs one access on a 64-bit doubleword memory bus with a req/ready handshake.
- Returns a sign- or zero-extended load result to writeback.
- Stalls the single-cycle core while the access is outstanding.

Parameters:
- TIMEOUT, 255: maximum BUS-state cycles waiting for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  current instruction is a load or store; held until stall is low
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV64 size/sign code
- req_addr  in  64  effective address (ALU result)
- req_wdata  in  64  store data (rs2)
- stall  out  1  hold PC and pipeline inputs
- resp_valid  out  1  access complete this cycle
- resp_rdata  out  64  extended load data; 0 for stores and faults
- fault  out  1  access rejected or timed out
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  64  doubleword-aligned address, req_addr with [2:0] = 0
- mem_be  out  8  byte enables
- mem_wdata  out  64  lane-shifted store data
- mem_ready  in  1  bus accepts the request (or returns read data) this cycle
- mem_rdata  in  64  read data, valid when mem_ready is 1 and mem_we is 0

Behaviour:
- Reset: clk and rst_n as decided; reset is asynchronous, active-low.
  - State goes to IDLE, timeout counter clears.
  - All outputs 0: stall, resp_valid, resp_rdata, fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
- Reset mid-access: mem_req drops immediately; the in-flight access is abandoned and never reported.
- Size encoding:
  - Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
  - Any other code is illegal.
- Misaligned: addr[2:0] not a multiple of the access size.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - stall = req_valid and not reject (combinational).
  - Reject = illegal funct3, or misaligned with LSU_MISALIGN_TRAP_EN defined.
  - Reject response (same cycle, combinational): fault=1, resp_valid=1, resp_rdata=0, stall=0, no bus activity.
  - Otherwise with req_valid: latch address, funct3, we and shifted data; go to BUS.
- BUS:
  - mem_req=1 and stall=1; mem_we, mem_addr, mem_be, mem_wdata stay stable until mem_ready.
  - On mem_ready: capture mem_rdata, clear counter, go to DONE.
  - If the counter reaches TIMEOUT without mem_ready (TIMEOUT>0): drop mem_req, set fault, go to DONE with resp_rdata=0.
- DONE:
  - Exactly one cycle: resp_valid=1, stall=0, registered resp_rdata and fault.
  - Always returns to IDLE; req_valid this cycle is the same instruction and is ignored.
  - A new access is accepted from the following cycle.
- Store lanes:
  - be = size mask (0x01/0x03/0x0F/0xFF) shifted left by addr[2:0].
  - wdata = req_wdata shifted left by 8*addr[2:0]; bits shifted past bit 63 are dropped.
- Load extract:
  - mem_rdata >> 8*addr[2:0], truncated to the access size.
  - LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend.
- Load bus phase drives mem_be for the accessed bytes and mem_wdata=0.
- Throughput: one access per 3 cycles minimum (IDLE, BUS, DONE) with mem_ready in the first BUS cycle.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses are rejected in IDLE with fault=1 and no bus access.
- Undefined: misaligned accesses proceed with addr[2:0] force-aligned to the access size, then follow normal lane rules; fault only for illegal funct3 or timeout.

Test Plan:
- LB at req_addr 0x1003, mem_rdata 0x1122334485667788, mem_ready first BUS cycle -> mem_addr 0x1000, mem_be 0x08; DONE gives resp_rdata 0xFFFFFFFFFFFFFF85. Repeat as LBU -> 0x0000000000000085.
- SH at 0x2006, req_wdata 0x000000000000ABCD -> mem_we=1, mem_addr 0x2000, mem_be 0xC0, mem_wdata 0xABCD000000000000; stall high 2 cycles, then resp_valid with resp_rdata 0.
- LD at 0x3000, mem_ready withheld 5 cycles -> mem_req and bus outputs stable all 5 cycles; DONE one cycle after mem_ready; stall low only in DONE.
- LW at 0x1002:
  - With macro: same-cycle fault=1, resp_valid=1, stall=0, mem_req never asserted.
  - Without macro: mem_addr 0x1000, mem_be 0x0F.
- TIMEOUT=4, load, mem_ready never asserted -> mem_req drops after 4 BUS cycles; DONE with fault=1, resp_rdata 0. Illegal funct3 111 -> immediate fault.
- rst_n pulsed low in the 2nd BUS cycle -> mem_req and stall go 0 asynchronously, no resp_valid; after release, a new SD at 0x4000 completes normally with mem_be 0xFF.

Source files
------------

// File: rtl/lsu_stage.sv
// lsu_stage: load/store unit placed directly after the ALU.
//
// Runs one access per instruction on a 64-bit doubleword bus with a
// req/ready handshake. While the access is outstanding it stalls the core,
// and it returns the sign- or zero-extended load result to writeback.
//
// Parameters:
//   TIMEOUT  maximum BUS-state cycles to wait for mem_ready (0 = wait forever)
//
// Optional build macro:
//   LSU_MISALIGN_TRAP_EN  when defined, a misaligned access faults in IDLE and
//                         never reaches the bus. When undefined, addr[2:0] is
//                         rounded down to the access size.
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   req_*             instruction side (valid, we, funct3, addr, wdata)
//   stall             hold PC and pipeline inputs
//   resp_valid/rdata  completion pulse and extended load data
//   fault             access rejected or timed out
//   mem_*             doubleword bus (req, we, addr, be, wdata, ready, rdata)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for req_valid; illegal requests are rejected here
// BUS   | mem_req held with stable bus outputs until mem_ready/timeout
// DONE  | one-cycle response; req_valid here is the finished instruction
module lsu_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

    localparam logic [15:0] CNT_LOAD = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

    state_t      state;
    logic [15:0] cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [2:0]  off_q;
    logic [60:0] dw_q;
    logic [7:0]  be_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic        fault_q;

    logic [2:0]  lo_mask;
    logic [7:0]  size_be;
    logic [2:0]  req_off;
    logic        illegal;
    logic        reject;
    logic [63:0] shifted;
    logic [63:0] load_ext;

    always_comb begin
        lo_mask = 3'b111;
        size_be = 8'hFF;
        case (req_funct3[1:0])
            2'd0: begin lo_mask = 3'b000; size_be = 8'h01; end
            2'd1: begin lo_mask = 3'b001; size_be = 8'h03; end
            2'd2: begin lo_mask = 3'b011; size_be = 8'h0F; end
            default: begin lo_mask = 3'b111; size_be = 8'hFF; end
        endcase
    end

    // Rounding the offset down only matters when misaligned accesses are let through.
    assign req_off = req_addr[2:0] & ~lo_mask;
    assign illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);

`ifdef LSU_MISALIGN_TRAP_EN
    assign reject = illegal | (|(req_addr[2:0] & lo_mask));
`else
    assign reject = illegal;
`endif

    assign shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (f3_q)
            3'b000: load_ext = {{56{shifted[7]}},  shifted[7:0]};
            3'b001: load_ext = {{48{shifted[15]}}, shifted[15:0]};
            3'b010: load_ext = {{32{shifted[31]}}, shifted[31:0]};
            3'b100: load_ext = {56'd0, shifted[7:0]};
            3'b101: load_ext = {48'd0, shifted[15:0]};
            3'b110: load_ext = {32'd0, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            dw_q    <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !reject) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= req_off;
                        dw_q    <= req_addr[63:3];
                        be_q    <= size_be << req_off;
                        wdata_q <= req_we ? (req_wdata << {req_off, 3'b000}) : 64'd0;
                        rdata_q <= '0;
                        fault_q <= 1'b0;
                        cnt     <= CNT_LOAD;
                        state   <= BUS;
                    end
                end
                BUS: begin
                    if (mem_ready) begin
                        rdata_q <= we_q ? 64'd0 : load_ext;
                        cnt     <= '0;
                        state   <= DONE;
                    end else if (TIMEOUT > 0 && cnt == 16'd0) begin
                        fault_q <= 1'b1;
                        rdata_q <= '0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus outputs are forced to zero outside BUS so nothing stale leaks onto the bus.
    always_comb begin
        mem_req    = (state == BUS);
        mem_we     = mem_req & we_q;
        mem_addr   = mem_req ? {dw_q, 3'b000} : 64'd0;
        mem_be     = mem_req ? be_q : 8'd0;
        mem_wdata  = mem_req ? wdata_q : 64'd0;
        stall      = mem_req | ((state == IDLE) & req_valid & ~reject);
        resp_valid = (state == DONE) | ((state == IDLE) & req_valid & reject);
        fault      = ((state == DONE) & fault_q) | ((state == IDLE) & req_valid & reject);
        resp_rdata = (state == DONE) ? rdata_q : 64'd0;
    end

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        mem_ready = 1'b0;
    logic        mem_ready_t = 1'b0;
    logic [63:0] mem_rdata = '0;

    logic        stall, resp_valid, fault, mem_req, mem_we;
    logic [63:0] resp_rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_be;

    logic        t_stall, t_resp_valid, t_fault, t_mem_req, t_mem_we;
    logic [63:0] t_resp_rdata, t_mem_addr, t_mem_wdata;
    logic [7:0]  t_mem_be;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    lsu_stage #(.TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Second instance with a short timeout; its bus never answers.
    lsu_stage #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(t_stall), .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .fault(t_fault),
        .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_be(t_mem_be),
        .mem_wdata(t_mem_wdata), .mem_ready(mem_ready_t), .mem_rdata(mem_rdata)
    );

    // Reference load result: pick the addressed bytes, then extend by funct3.
    function automatic logic [63:0] load_model(input logic [2:0] f3, input int off,
                                               input int sz, input logic [63:0] rd);
        logic [63:0] v, m;
        v = rd >> (8 * off);
        if (sz == 8) return v;
        m = (64'd1 << (8 * sz)) - 64'd1;
        v = v & m;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~m;
        return v;
    endfunction

    // Drives one instruction from IDLE to completion and checks every cycle.
    task automatic do_access(input string nm, input bit we, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] wd,
                             input logic [63:0] rd, input int dly);
        int sz, lo, off;
        bit rej;
        logic [63:0] ea, ew, er;
        logic [7:0] eb;
        sz  = 1 << f3[1:0];
        lo  = int'(addr[2:0]);
        off = lo - (lo % sz);
        rej = we ? (f3 > 3'd3) : (f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        if (lo % sz != 0) rej = 1'b1;
`endif
        ea = addr - 64'(lo);
        eb = 8'(((1 << sz) - 1) << off);
        ew = we ? (wd << (8 * off)) : 64'd0;
        er = we ? 64'd0 : load_model(f3, off, sz, rd);

        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; mem_ready = 1'b0;
        #1;
        if (rej) begin
            tests++;
            if ({resp_valid, fault, stall, mem_req, resp_rdata} !== {4'b1100, 64'd0}) begin
                failed++;
                $display("FAIL %s reject: got rv/f/st/req=%b rdata=%h want 1100 0", nm,
                         {resp_valid, fault, stall, mem_req}, resp_rdata);
            end
            @(negedge clk); req_valid = 1'b0; #1;
            tests++;
            if ({resp_valid, stall, mem_req} !== 3'b000) begin
                failed++;
                $display("FAIL %s after_reject: got rv/st/req=%b want 000", nm,
                         {resp_valid, stall, mem_req});
            end
            return;
        end
        tests++;
        if ({stall, mem_req, resp_valid, fault} !== 4'b1000) begin
            failed++;
            $display("FAIL %s idle: got st/req/rv/f=%b want 1000", nm,
                     {stall, mem_req, resp_valid, fault});
        end
        for (int c = 0; c <= dly; c++) begin
            @(negedge clk);
            if (c == dly) begin mem_ready = 1'b1; mem_rdata = rd; end
            else mem_rdata = {$urandom, $urandom};
            #1;
            tests++;
            if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, resp_valid} !==
                {1'b1, we, ea, eb, ew, 1'b1, 1'b0}) begin
                failed++;
                $display("FAIL %s bus c%0d: got req=%b we=%b a=%h be=%h wd=%h st=%b rv=%b want we=%b a=%h be=%h wd=%h",
                         nm, c, mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, resp_valid,
                         we, ea, eb, ew);
            end
        end
        @(negedge clk); mem_ready = 1'b0; mem_rdata = {$urandom, $urandom}; #1;
        tests++;
        if ({resp_valid, fault, stall, mem_req, resp_rdata} !== {4'b1000, er}) begin
            failed++;
            $display("FAIL %s done: got rv/f/st/req=%b rdata=%h want 1000 %h", nm,
                     {resp_valid, fault, stall, mem_req}, resp_rdata, er);
        end
        @(negedge clk); req_valid = 1'b0; #1;
        tests++;
        if ({resp_valid, stall, mem_req} !== 3'b000) begin
            failed++;
            $display("FAIL %s after_done: got rv/st/req=%b want 000", nm,
                     {resp_valid, stall, mem_req});
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({stall, resp_valid, resp_rdata, fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
            failed++;
            $display("FAIL reset_state: outputs not all zero (st=%b rv=%b req=%b a=%h)",
                     stall, resp_valid, mem_req, mem_addr);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_access("lb",  1'b0, 3'b000, 64'h1003, 64'h0, 64'h1122334485667788, 0);
        do_access("lbu", 1'b0, 3'b100, 64'h1003, 64'h0, 64'h1122334485667788, 0);
        do_access("sh",  1'b1, 3'b001, 64'h2006, 64'h000000000000ABCD, 64'h0, 0);
        do_access("ld_wait5", 1'b0, 3'b011, 64'h3000, 64'h0, 64'hDEADBEEF01234567, 5);
        do_access("lw_misal", 1'b0, 3'b010, 64'h1002, 64'h0, 64'h8765432112345678, 0);
        do_access("ill_111", 1'b0, 3'b111, 64'h1000, 64'h0, 64'h0, 0);
        do_access("ill_st",  1'b1, 3'b101, 64'h1000, 64'h55, 64'h0, 0);
        do_access("lwu",  1'b0, 3'b110, 64'h10C4, 64'h0, 64'h80000001_7FFFFFFF, 1);
    endtask

    task automatic test_mid_reset();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h3008;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        tests++;
        if (mem_req !== 1'b1) begin
            failed++;
            $display("FAIL mid_reset_pre: got mem_req=%b want 1", mem_req);
        end
        rst_n = 1'b0; req_valid = 1'b0; #1;
        tests++;
        if ({mem_req, stall, resp_valid, fault, mem_addr, mem_be} !== '0) begin
            failed++;
            $display("FAIL mid_reset_async: got req=%b st=%b rv=%b a=%h want all 0",
                     mem_req, stall, resp_valid, mem_addr);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            tests++;
            if ({resp_valid, mem_req} !== 2'b00) begin
                failed++;
                $display("FAIL mid_reset_quiet%0d: got rv/req=%b want 00", i, {resp_valid, mem_req});
            end
        end
        do_access("sd_after_rst", 1'b1, 3'b011, 64'h4000, 64'h0123456789ABCDEF, 64'h0, 1);
    endtask

    task automatic test_timeout();
        rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h5000;
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            tests++;
            if ({t_mem_req, t_stall, t_resp_valid} !== 3'b110) begin
                failed++;
                $display("FAIL timeout_bus%0d: got req/st/rv=%b want 110", c,
                         {t_mem_req, t_stall, t_resp_valid});
            end
        end
        @(negedge clk); #1;
        tests++;
        if ({t_resp_valid, t_fault, t_stall, t_mem_req, t_resp_rdata} !== {4'b1100, 64'd0}) begin
            failed++;
            $display("FAIL timeout_done: got rv/f/st/req=%b rdata=%h want 1100 0",
                     {t_resp_valid, t_fault, t_stall, t_mem_req}, t_resp_rdata);
        end
        tests++;
        if (mem_req !== 1'b1) begin
            failed++;
            $display("FAIL long_timeout_still_bus: got mem_req=%b want 1", mem_req);
        end
        @(negedge clk); req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0; #1;
        tests++;
        if ({resp_valid, fault, t_mem_req, t_resp_valid} !== 4'b1000) begin
            failed++;
            $display("FAIL timeout_cleanup: got rv/f/t_req/t_rv=%b want 1000",
                     {resp_valid, fault, t_mem_req, t_resp_valid});
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit we;
            logic [2:0] f3;
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
            do_access($sformatf("rnd%0d", i), we, f3, {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mid_reset();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
